// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
// Purpose : shared definitions for the load/store unit. Holds the access size
//           encodings, the FSM state encoding and small helpers that describe
//           which byte lanes an access covers and whether it spills into the
//           following memory word.
// Ports   : none (package)
// Config  : MISALIGN_TRAP_EN is consumed by load_store_unit, not here.
// -----------------------------------------------------------------------------
package load_store_unit_pkg;

    // Access size encodings; 2'b11 is treated as a word everywhere.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC0 = 2'd1;
    localparam logic [1:0] ST_ACC1 = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Byte lanes touched by an access that starts at lane 0.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001;
            SZ_HALF: mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    // True when the access at this byte offset runs past the end of its word.
    function automatic logic is_straddle(input logic [1:0] offset,
                                         input logic [1:0] size);
        logic straddle;
        case (size)
            SZ_BYTE: straddle = 1'b0;
            SZ_HALF: straddle = (offset == 2'd3);
            default: straddle = (offset != 2'd0);
        endcase
        return straddle;
    endfunction

endpackage

// File: rtl/load_store_unit_lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purpose : purely combinational data steering for the load/store unit.
//           Store side: merges right-aligned store data into one memory word
//           (pass 0 = first word, pass 1 = spill-over word) leaving uncovered
//           bytes as read from memory.
//           Load side: extracts the addressed bytes from the two buffered words
//           and sign- or zero-extends them to 32 bits.
// Ports   : i_word     current memory word (read-modify-write source)
//           i_wdata    right-aligned store data
//           i_offset   byte offset of the access within its first word
//           i_size     access size (SZ_BYTE/SZ_HALF/SZ_WORD, 11 = word)
//           i_pass     0 = first word of the access, 1 = second word
//           o_merged   word to write back to memory
//           i_buf0     first loaded word
//           i_buf1     second loaded word (only meaningful for straddles)
//           i_unsigned 1 = zero-extend, 0 = sign-extend
//           o_load     extended load result
// -----------------------------------------------------------------------------
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_pass,
    output logic [31:0] o_merged,
    input  logic [31:0] i_buf0,
    input  logic [31:0] i_buf1,
    input  logic        i_unsigned,
    output logic [31:0] o_load
);

    logic [7:0]  w_laneMask;
    logic [63:0] w_shiftData;
    logic [3:0]  w_mask;
    logic [31:0] w_data;
    logic [63:0] w_pair;
    logic [31:0] w_low;

    // Store merge: view the access as an 8-byte window spanning two words.
    // The shifted data and lane mask are split so that pass 0 takes the low
    // half (first word) and pass 1 the high half (spill-over word).
    always_comb begin
        w_laneMask  = {4'b0000, size_mask(i_size)} << i_offset;
        w_shiftData = {32'h0, i_wdata} << {i_offset, 3'b000};
        w_mask      = i_pass ? w_laneMask[7:4]   : w_laneMask[3:0];
        w_data      = i_pass ? w_shiftData[63:32] : w_shiftData[31:0];
        for (int b = 0; b < 4; b++) begin
            o_merged[b*8 +: 8] = w_mask[b] ? w_data[b*8 +: 8] : i_word[b*8 +: 8];
        end
    end

    // Load extract: shift the two-word pair down so the first addressed byte
    // lands at bit 0, then truncate to size and extend.
    always_comb begin
        w_pair = {i_buf1, i_buf0} >> {i_offset, 3'b000};
        w_low  = w_pair[31:0];
        case (i_size)
            SZ_BYTE: o_load = i_unsigned ? {24'h0, w_low[7:0]}
                                         : {{24{w_low[7]}}, w_low[7:0]};
            SZ_HALF: o_load = i_unsigned ? {16'h0, w_low[15:0]}
                                         : {{16{w_low[15]}}, w_low[15:0]};
            default: o_load = w_low;
        endcase
    end

    // Upper half of the shifted pair is never needed for the result.
    logic w_unusedPair;
    assign w_unusedPair = ^w_pair[63:32];

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Purpose : byte/half/word load-store front end for a word-organised data
//           memory with combinational read and posedge write. Sub-word stores
//           are done as same-cycle read-modify-write; accesses that cross a
//           word boundary are split into two word accesses.
// Config  : `define MISALIGN_TRAP_EN to reject straddling accesses instead of
//           splitting them (resp_err = 1, no memory write, 1-cycle response).
// Ports   : clk, rst_n                 clock, synchronous active-low reset
//           req_valid/req_ready        request handshake (ready in IDLE only)
//           req_we, req_size,
//           req_unsigned, req_addr,
//           req_wdata                  request attributes, byte address
//           resp_valid, resp_rdata,
//           resp_err                   one-cycle completion pulse and data
//           mem_addr, mem_wd, mem_we   word index / write port to memory
//           mem_rd                     combinational read data for mem_addr
// -----------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    output logic              mem_we,
    input  logic [31:0]       mem_rd
);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_index;
    logic [1:0]        r_offset;
    logic [1:0]        r_size;
    logic              r_we;
    logic              r_unsigned;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf0;
    logic [31:0]       r_buf1;

    logic              w_straddle;
    logic              w_inAcc;
    logic              w_pass;
    logic [31:0]       w_merged;
    logic [31:0]       w_load;
    logic              w_errResp;

    assign w_straddle = is_straddle(r_offset, r_size);
    assign w_inAcc    = (r_state == ST_ACC0) || (r_state == ST_ACC1);
    assign w_pass     = (r_state == ST_ACC1);

`ifdef MISALIGN_TRAP_EN
    logic w_reqStraddle;
    logic r_err;
    assign w_reqStraddle = is_straddle(req_addr[1:0], req_size);
    assign w_errResp     = r_err;
`else
    assign w_errResp     = 1'b0;
`endif

    lsu_align u_align (
        .i_word     (mem_rd),
        .i_wdata    (r_wdata),
        .i_offset   (r_offset),
        .i_size     (r_size),
        .i_pass     (w_pass),
        .o_merged   (w_merged),
        .i_buf0     (r_buf0),
        .i_buf1     (r_buf1),
        .i_unsigned (r_unsigned),
        .o_load     (w_load)
    );

    // Main FSM: latch the request in IDLE, touch one or two memory words,
    // then present a single response cycle. A reset at any point abandons
    // the access; the combinational mem_we gate below drops any pending write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_index    <= '0;
            r_offset   <= 2'b00;
            r_size     <= SZ_BYTE;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_wdata    <= 32'h0;
            r_buf0     <= 32'h0;
            r_buf1     <= 32'h0;
`ifdef MISALIGN_TRAP_EN
            r_err      <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_index    <= req_addr[ADDR_W+1:2];
                        r_offset   <= req_addr[1:0];
                        r_size     <= req_size;
                        r_we       <= req_we;
                        r_unsigned <= req_unsigned;
                        r_wdata    <= req_wdata;
                        r_buf0     <= 32'h0;
                        r_buf1     <= 32'h0;
`ifdef MISALIGN_TRAP_EN
                        // Straddling accesses are refused without touching memory.
                        r_err      <= w_reqStraddle;
                        r_state    <= w_reqStraddle ? ST_RESP : ST_ACC0;
`else
                        r_state    <= ST_ACC0;
`endif
                    end
                end
                ST_ACC0: begin
                    if (!r_we) begin
                        r_buf0 <= mem_rd;
                    end
                    r_state <= w_straddle ? ST_ACC1 : ST_RESP;
                end
                ST_ACC1: begin
                    if (!r_we) begin
                        r_buf1 <= mem_rd;
                    end
                    r_state <= ST_RESP;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory side: the second access uses the next word index, wrapping
    // naturally at the top of memory. Write enable is gated by rst_n so a
    // reset asserted mid-access never commits the pending word.
    always_comb begin
        mem_addr = (r_state == ST_ACC1) ? r_index + ADDR_W'(1) : r_index;
        mem_we   = rst_n & w_inAcc & r_we;
        mem_wd   = (w_inAcc && r_we) ? w_merged : 32'h0;
    end

    // Request/response side.
    always_comb begin
        req_ready  = (r_state == ST_IDLE);
        resp_valid = (r_state == ST_RESP);
        resp_rdata = (resp_valid && !r_we && !w_errResp) ? w_load : 32'h0;
        resp_err   = resp_valid & w_errResp;
    end

    // Address bits above the memory index are intentionally ignored.
    logic w_unusedAddr;
    assign w_unusedAddr = ^req_addr[31:ADDR_W+2];

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the ALU/register-file datapath and the word-organised data memory (combinational read, posedge write).
- Accepts byte, halfword and word loads/stores at any byte address.
- Drives the memory's address, write-data and write-enable.
- Consumes the memory's read data and returns a sign- or zero-extended load result.
- Splits accesses that straddle two words into two word accesses. Performs read-modify-write for sub-word stores.

Parameters:
- ADDR_W, 5, word-index width of the data memory. Depth is 2**ADDR_W words.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (IDLE only).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_unsigned  in  1  load zero-extends when 1.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  misaligned flag; constant 0 unless MISALIGN_TRAP_EN.
- mem_addr  out  ADDR_W  word index to data memory.
- mem_wd  out  32  write data to data memory.
- mem_we  out  1  write enable to data memory.
- mem_rd  in  32  combinational read data for mem_addr.

Behaviour:
Data layout and addressing:
- Little-endian.
- Word index = req_addr[ADDR_W+1:2]. Higher address bits are ignored.
- Offset = req_addr[1:0].

Straddle rule:
- Byte never straddles.
- Half straddles when offset == 3.
- Word straddles when offset != 0.

State machine: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch addr/size/we/wdata/unsigned and go to ACC0.
  - No request: stay in IDLE.
- ACC0:
  - mem_addr = latched index.
  - Load: register mem_rd into buf0.
  - Store: mem_we = 1; mem_wd = mem_rd with the bytes covered in this word replaced by the shifted wdata bytes. This is the same-cycle read-modify-write.
  - Next state: ACC1 if the access straddles, else RESP.
- ACC1:
  - mem_addr = index + 1, wrapping modulo 2**ADDR_W.
  - Load: register mem_rd into buf1.
  - Store: merge the remaining upper bytes into low bytes of this word; mem_we = 1.
  - Next state: RESP.
- RESP:
  - resp_valid = 1.
  - resp_rdata = {buf1,buf0} shifted right by offset*8, truncated to size, then sign- or zero-extended. Stores return 0.
  - Next state: IDLE. No response backpressure.

Latency from accept cycle T:
- Aligned: resp_valid at T+2.
- Straddling: resp_valid at T+3.
- Next accept is possible at resp cycle + 1.

Outputs outside ACC0/ACC1:
- mem_we = 0, mem_wd = 0, mem_addr = latched index.

Reset (rst_n low at a posedge):
- state = IDLE; all latches, buffers and outputs cleared.
- req_ready = 1 from the first cycle after release.
- mem_we is forced 0 combinationally while rst_n is low.
- Reset mid-operation: any not-yet-performed word write is dropped and no resp_valid is issued.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - Any straddling access goes ACC0-skip: IDLE → RESP directly.
  - No memory write.
  - resp_err = 1, resp_rdata = 0.
  - Latency is T+1.
- Undefined:
  - Straddling accesses are split as above.
  - resp_err is tied 0.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state encoding;
  - byte-lane mask function.
- One sub-module, lsu_align: combinational store byte-merge (word data + offset + size + pass → merged word) and load extract/extend. The FSM stays in load_store_unit.

Test Plan:
1. sw 0xDEADBEEF @0x08, then lw @0x08 → resp_rdata 0xDEADBEEF; resp_valid exactly at T+2; mem_we high exactly one cycle during the store.
2. word1 = 0x11223344; sb 0xAB @0x05 → word1 = 0x1122AB44; lb @0x05 → 0xFFFFFFAB; lbu @0x05 → 0x000000AB.
3. word1 = 0x11223344, word2 = 0x55667788; lw @0x06 → 0x77881122; resp_valid at T+3; mem_addr 1 then 2.
4. sh 0xBEEF @0x07 → word1[31:24] = 0xEF, word2[7:0] = 0xBE; other bytes unchanged.
5. ADDR_W = 5, word31 = 0xAA000000, word0 = 0x000000BB; lhu @0x7F → 0x0000BBAA (index wraps 31→0).
6. Reset asserted in ACC1 of a straddling sw @0x06 → word2 unchanged; no resp_valid; req_ready = 1 the cycle after release. With MISALIGN_TRAP_EN: same sw → resp_err = 1 at T+1 and memory unchanged.
